// File: rtl/shared_kes_channel_scheduler.sv
// shared_kes_channel_scheduler: round-robin front end sharing one BCH KES engine across page-decoder channels.
//   iClock, iReset            clock, asynchronous active-high reset
//   iErrorDetectionEnd        per-chunk detection-done strobes, channel c at [c*Multi +: Multi]
//   iDecodeNeeded             per-chunk decode-needed flags, sampled with the strobes
//   iSyndromes                per-chunk syndromes, chunk (c,k) at (c*Multi+k)*GFD*Syn
//   oSharedKESReady           per-channel slot empty
//   iKESAvailable             KES can accept a chunk
//   oExecuteKES               one-cycle issue strobe
//   oErroredChunkNumber       chunk index of the issued chunk
//   oDataFowarding            issued chunk needs no decode
//   oLastChunk                issued chunk is the last of its cluster
//   oSyndromes                syndromes of the issued chunk
//   oChannelSel               one-hot owner of the issued chunk
module shared_kes_channel_scheduler #(
    parameter int Channel           = 4,
    parameter int Multi             = 2,
    parameter int GaloisFieldDegree = 12,
    parameter int Syndromes         = 27,
    parameter int ChunkBits         = (Multi > 1) ? $clog2(Multi) : 1
) (
    input  logic                                                iClock,
    input  logic                                                iReset,
    input  logic [Channel*Multi-1:0]                            iErrorDetectionEnd,
    input  logic [Channel*Multi-1:0]                            iDecodeNeeded,
    input  logic [Channel*Multi*GaloisFieldDegree*Syndromes-1:0] iSyndromes,
    output logic [Channel-1:0]                                  oSharedKESReady,
    input  logic                                                iKESAvailable,
    output logic                                                oExecuteKES,
    output logic [ChunkBits-1:0]                                oErroredChunkNumber,
    output logic                                                oDataFowarding,
    output logic                                                oLastChunk,
    output logic [GaloisFieldDegree*Syndromes-1:0]              oSyndromes,
    output logic [Channel-1:0]                                  oChannelSel
);
    localparam int SynWidth = GaloisFieldDegree * Syndromes;
    localparam int PtrBits  = $clog2(Channel);
    localparam int Slots    = Channel * Multi;
    localparam int SlotBits = $clog2(Slots);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} stateType;

    stateType              state;
    logic [Channel-1:0]    slotFull;
    logic [Channel-1:0]    captureEn;
    logic [SynWidth-1:0]   slotSyn [Slots];
    logic                  slotDec [Slots];
    logic [PtrBits-1:0]    rrPtr;
    logic [PtrBits-1:0]    sel;
    logic [PtrBits-1:0]    nextSel;
    logic [PtrBits-1:0]    cand;
    logic [ChunkBits-1:0]  chunk;
    logic [SlotBits-1:0]   slotIdx;
    logic [Channel-1:0]    selOneHot;

    assign oSharedKESReady = ~slotFull;
    assign slotIdx         = SlotBits'(int'(sel) * Multi + int'(chunk));
    assign selOneHot       = Channel'(1) << sel;

    // A strobe only captures into an empty slot; a full slot keeps its original data.
    genvar c, s;
    for (c = 0; c < Channel; c++) begin : g_cap
        assign captureEn[c] = ~slotFull[c] & |iErrorDetectionEnd[c*Multi +: Multi];
    end

    for (s = 0; s < Slots; s++) begin : g_slot
        always_ff @(posedge iClock) begin
            if (captureEn[s/Multi]) begin
                slotSyn[s] <= iSyndromes[s*SynWidth +: SynWidth];
                slotDec[s] <= iDecodeNeeded[s];
            end
        end
    end

    // Scan downward from rrPtr+Channel-1 so the last hit is the first full slot at or after rrPtr.
    always_comb begin
        nextSel = rrPtr;
        cand    = rrPtr;
        for (int i = Channel - 1; i >= 0; i--) begin
            cand = PtrBits'((int'(rrPtr) + i) % Channel);
            if (slotFull[cand]) nextSel = cand;
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state               <= IDLE;
            slotFull            <= '0;
            rrPtr               <= '0;
            sel                 <= '0;
            chunk               <= '0;
            oExecuteKES         <= 1'b0;
            oErroredChunkNumber <= '0;
            oDataFowarding      <= 1'b0;
            oLastChunk          <= 1'b0;
            oSyndromes          <= '0;
            oChannelSel         <= '0;
        end else begin
            slotFull <= (slotFull | captureEn) & ~((state == RELEASE) ? selOneHot : '0);
            case (state)
                IDLE: if (|slotFull) begin
                    sel   <= nextSel;
                    chunk <= '0;
                    state <= ISSUE;
                end
                ISSUE: if (iKESAvailable) begin
                    oExecuteKES         <= 1'b1;
                    oErroredChunkNumber <= chunk;
                    oDataFowarding      <= ~slotDec[slotIdx];
                    oLastChunk          <= chunk == ChunkBits'(Multi - 1);
                    oSyndromes          <= slotSyn[slotIdx];
                    oChannelSel         <= selOneHot;
                    state               <= WAIT;
                end
                WAIT: begin
                    oExecuteKES <= 1'b0;
                    chunk       <= (chunk == ChunkBits'(Multi - 1)) ? chunk : chunk + 1'b1;
                    state       <= (chunk == ChunkBits'(Multi - 1)) ? RELEASE : ISSUE;
                end
                default: begin
                    rrPtr <= (sel == PtrBits'(Channel - 1)) ? '0 : sel + 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
